// File: rtl/dom_and_pipe_if.sv
// rtl/dom_and_pipe_if.sv - share-packed operand/result bundle for dom_and_pipe
interface dom_and_pipe_if #(
  parameter int ORDER = 2,
  parameter int WIDTH = 1
);
  localparam int SW = (ORDER + 1) * WIDTH;
  localparam int RW = WIDTH * ORDER * (ORDER + 1) / 2;

  logic          io_in_valid;
  logic [SW-1:0] io_i0;
  logic [SW-1:0] io_i1;
  logic [RW-1:0] p_rand;
  logic          io_out_valid;
  logic [SW-1:0] io_o0;

  modport master (
    output io_in_valid, io_i0, io_i1, p_rand,
    input  io_out_valid, io_o0
  );

  modport slave (
    input  io_in_valid, io_i0, io_i1, p_rand,
    output io_out_valid, io_o0
  );
endinterface

// File: rtl/dom_and_pipe.sv
// rtl/dom_and_pipe.sv - DOM masked AND, resharing register split from compression
// Optional output register stage: define DOM_AND_OUT_REG_EN (latency 2, otherwise 1).
module dom_and_pipe #(
  parameter int ORDER = 2,
  parameter int WIDTH = 1
) (
  input logic           clock_0,
  input logic           reset_0,
  dom_and_pipe_if.slave bus
);
  localparam int N  = ORDER + 1;
  localparam int NP = ORDER * (ORDER + 1) / 2;

  logic [N-1:0][WIDTH-1:0]  a, b, inner_d, inner_q, c;
  logic [NP-1:0][WIDTH-1:0] rnd, cij_d, cji_d, cij_q, cji_q;
  logic                     v1_q;

  // Lexicographic index of pair (i,j), i<j.
  function automatic int pidx(input int i, input int j);
    return i * N - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  assign a   = bus.io_i0;
  assign b   = bus.io_i1;
  assign rnd = bus.p_rand;

  // Each cross term is masked by its pair's randomness and registered on its own.
  always_comb begin
    inner_d = '0;
    cij_d   = '0;
    cji_d   = '0;
    for (int i = 0; i < N; i++) begin
      inner_d[i] = a[i] & b[i];
      for (int j = i + 1; j < N; j++) begin
        cij_d[pidx(i, j)] = (a[i] & b[j]) ^ rnd[pidx(i, j)];
        cji_d[pidx(i, j)] = (a[j] & b[i]) ^ rnd[pidx(i, j)];
      end
    end
  end

  always_ff @(posedge clock_0 or negedge reset_0) begin
    if (!reset_0) begin
      inner_q <= '0;
      cij_q   <= '0;
      cji_q   <= '0;
      v1_q    <= 1'b0;
    end else begin
      v1_q <= bus.io_in_valid;
      if (bus.io_in_valid) begin
        inner_q <= inner_d;
        cij_q   <= cij_d;
        cji_q   <= cji_d;
      end
    end
  end

  always_comb begin
    c = '0;
    for (int i = 0; i < N; i++) begin
      c[i] = inner_q[i];
    end
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        c[i] = c[i] ^ cij_q[pidx(i, j)];
        c[j] = c[j] ^ cji_q[pidx(i, j)];
      end
    end
  end

`ifdef DOM_AND_OUT_REG_EN
  logic [N-1:0][WIDTH-1:0] out_q;
  logic                    v2_q;

  always_ff @(posedge clock_0 or negedge reset_0) begin
    if (!reset_0) begin
      out_q <= '0;
      v2_q  <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        out_q <= c;
      end
    end
  end

  assign bus.io_o0        = out_q;
  assign bus.io_out_valid = v2_q;
`else
  assign bus.io_o0        = c;
  assign bus.io_out_valid = v1_q;
`endif
endmodule

// File: tb/tb_dom_and_pipe.sv
// tb/tb_dom_and_pipe.sv - randomized self-checking bench for dom_and_pipe
// Covers ORDER/WIDTH = 2/1, 1/8, 3/4; latency follows DOM_AND_OUT_REG_EN.
module tb_dom_and_pipe;
`ifdef DOM_AND_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clock_0 = 1'b0;
  logic reset_0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [63:0] st_v [1024];
  logic [63:0] st_a [1024];
  logic [63:0] st_b [1024];
  logic [63:0] st_r [1024];
  logic [63:0] last_o [3];

  always #5 clock_0 = ~clock_0;

  dom_and_pipe_if #(.ORDER(2), .WIDTH(1)) bus_a ();
  dom_and_pipe_if #(.ORDER(1), .WIDTH(8)) bus_b ();
  dom_and_pipe_if #(.ORDER(3), .WIDTH(4)) bus_c ();

  dom_and_pipe #(.ORDER(2), .WIDTH(1)) u_a (.clock_0(clock_0), .reset_0(reset_0), .bus(bus_a.slave));
  dom_and_pipe #(.ORDER(1), .WIDTH(8)) u_b (.clock_0(clock_0), .reset_0(reset_0), .bus(bus_b.slave));
  dom_and_pipe #(.ORDER(3), .WIDTH(4)) u_c (.clock_0(clock_0), .reset_0(reset_0), .bus(bus_c.slave));

  function automatic int ord_of(input int sel);
    return (sel == 0) ? 2 : (sel == 1) ? 1 : 3;
  endfunction

  function automatic int wid_of(input int sel);
    return (sel == 0) ? 1 : (sel == 1) ? 8 : 4;
  endfunction

  // Reference: walk pairs in order, consuming one randomness slice per pair.
  function automatic logic [63:0] dom_model(input int sel, input logic [63:0] a,
                                            input logic [63:0] b, input logic [63:0] r);
    int          n = ord_of(sel) + 1;
    int          w = wid_of(sel);
    int          k = 0;
    logic [63:0] m = (64'd1 << w) - 64'd1;
    logic [63:0] c = 64'd0;
    logic [63:0] rk, t;
    for (int i = 0; i < n; i++)
      c = c | ((((a >> (i * w)) & (b >> (i * w))) & m) << (i * w));
    for (int i = 0; i < n; i++) begin
      for (int j = i + 1; j < n; j++) begin
        rk = (r >> (k * w)) & m;
        t  = (((a >> (i * w)) & (b >> (j * w))) & m) ^ rk;
        c  = c ^ (t << (i * w));
        t  = (((a >> (j * w)) & (b >> (i * w))) & m) ^ rk;
        c  = c ^ (t << (j * w));
        k++;
      end
    end
    return c;
  endfunction

  function automatic logic [63:0] share_xor(input int sel, input logic [63:0] v);
    int          w = wid_of(sel);
    logic [63:0] m = (64'd1 << w) - 64'd1;
    logic [63:0] x = 64'd0;
    for (int s = 0; s <= ord_of(sel); s++) x = x ^ ((v >> (s * w)) & m);
    return x;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] r);
    case (sel)
      0: begin
        bus_a.io_in_valid = v; bus_a.io_i0 = a[2:0]; bus_a.io_i1 = b[2:0]; bus_a.p_rand = r[2:0];
      end
      1: begin
        bus_b.io_in_valid = v; bus_b.io_i0 = a[15:0]; bus_b.io_i1 = b[15:0]; bus_b.p_rand = r[7:0];
      end
      default: begin
        bus_c.io_in_valid = v; bus_c.io_i0 = a[15:0]; bus_c.io_i1 = b[15:0]; bus_c.p_rand = r[23:0];
      end
    endcase
  endtask

  task automatic sample(input int sel, output logic v, output logic [63:0] o);
    case (sel)
      0:       begin v = bus_a.io_out_valid; o = 64'(bus_a.io_o0); end
      1:       begin v = bus_b.io_out_valid; o = 64'(bus_b.io_o0); end
      default: begin v = bus_c.io_out_valid; o = 64'(bus_c.io_o0); end
    endcase
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Plays st_* entries 0..n-1 into DUT sel, checking each output cycle against the model.
  task automatic run_stream(input int sel, input int n, input string name);
    logic        ov;
    logic [63:0] oo;
    int          s;
    for (int t = 0; t < n + LAT; t++) begin
      @(negedge clock_0);
      if (t >= LAT) begin
        s = t - LAT;
        sample(sel, ov, oo);
        if (st_v[s][0]) last_o[sel] = dom_model(sel, st_a[s], st_b[s], st_r[s]);
        n_cmp++;
        if (ov !== st_v[s][0]) begin
          n_err++;
          $display("FAIL %s valid[%0d]: got %b want %b", name, s, ov, st_v[s][0]);
        end
        n_cmp++;
        if (oo !== last_o[sel]) begin
          n_err++;
          $display("FAIL %s o0[%0d]: got %h want %h", name, s, oo, last_o[sel]);
        end
        if (st_v[s][0]) begin
          n_cmp++;
          if (share_xor(sel, oo) !== (share_xor(sel, st_a[s]) & share_xor(sel, st_b[s]))) begin
            n_err++;
            $display("FAIL %s invariant[%0d]: got %h want %h", name, s, share_xor(sel, oo),
                     share_xor(sel, st_a[s]) & share_xor(sel, st_b[s]));
          end
        end
      end
      if (t < n) drive(sel, st_v[t][0], st_a[t], st_b[t], st_r[t]);
      else       drive(sel, 1'b0, rnd64(), rnd64(), rnd64());
    end
  endtask

  task automatic test_reset();
    logic        ov;
    logic [63:0] oo;
    reset_0 = 1'b0;
    for (int s = 0; s < 3; s++) begin
      drive(s, 1'b0, 64'd0, 64'd0, 64'd0);
      last_o[s] = 64'd0;
    end
    @(negedge clock_0);
    for (int s = 0; s < 3; s++) begin
      sample(s, ov, oo);
      n_cmp++;
      if (ov !== 1'b0) begin n_err++; $display("FAIL reset_valid[%0d]: got %b want 0", s, ov); end
      n_cmp++;
      if (oo !== 64'd0) begin n_err++; $display("FAIL reset_o0[%0d]: got %h want 0", s, oo); end
    end
    reset_0 = 1'b1;
  endtask

  task automatic test_first_bundle();
    logic        ov;
    logic [63:0] oo, want;
    drive(0, 1'b1, 64'b001, 64'b111, 64'b000);
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge clock_0);
      sample(0, ov, oo);
      want = (k >= LAT) ? 64'b001 : 64'd0;
      n_cmp++;
      if (ov !== (k == LAT)) begin
        n_err++; $display("FAIL first_valid@%0d: got %b want %b", k, ov, (k == LAT));
      end
      n_cmp++;
      if (oo !== want) begin n_err++; $display("FAIL first_o0@%0d: got %h want %h", k, oo, want); end
      drive(0, 1'b0, rnd64(), rnd64(), rnd64());
    end
    last_o[0] = 64'b001;
  endtask

  task automatic test_exhaustive();
    for (int i = 0; i < 512; i++) begin
      st_v[i] = 64'd1;
      st_a[i] = 64'((i >> 6) & 7);
      st_b[i] = 64'((i >> 3) & 7);
      st_r[i] = 64'(i & 7);
    end
    run_stream(0, 512, "exhaustive");
  endtask

  task automatic test_order1_w8();
    logic        ov;
    logic [63:0] oo;
    drive(1, 1'b1, 64'h00A5, 64'h0FFF, 64'h3C);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clock_0);
      sample(1, ov, oo);
      n_cmp++;
      if (ov !== (k == LAT)) begin
        n_err++; $display("FAIL o1w8_valid@%0d: got %b want %b", k, ov, (k == LAT));
      end
      if (k == LAT) begin
        n_cmp++;
        if (oo !== 64'h3C9C) begin n_err++; $display("FAIL o1w8_o0: got %h want 3c9c", oo); end
        n_cmp++;
        if ((oo[7:0] ^ oo[15:8]) !== 8'hA0) begin
          n_err++; $display("FAIL o1w8_xor: got %h want a0", oo[7:0] ^ oo[15:8]);
        end
      end
      drive(1, 1'b0, rnd64(), rnd64(), rnd64());
    end
    last_o[1] = 64'h3C9C;
  endtask

  task automatic test_bubble();
    for (int i = 0; i < 3; i++) begin
      st_v[i] = (i == 1) ? 64'd0 : 64'd1;
      st_a[i] = rnd64();
      st_b[i] = rnd64();
      st_r[i] = rnd64();
    end
    run_stream(0, 3, "bubble");
  endtask

  task automatic test_reset_mid();
    logic        ov;
    logic [63:0] oo;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock_0);
      drive(0, 1'b1, rnd64(), rnd64(), rnd64());
    end
    @(posedge clock_0);
    #2;
    n_cmp++;
    if (bus_a.io_out_valid !== 1'b1) begin
      n_err++; $display("FAIL midrst_pre_valid: got %b want 1", bus_a.io_out_valid);
    end
    reset_0 = 1'b0;
    #1;
    sample(0, ov, oo);
    n_cmp++;
    if (ov !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", ov); end
    n_cmp++;
    if (oo !== 64'd0) begin n_err++; $display("FAIL midrst_o0: got %h want 0", oo); end
    @(negedge clock_0);
    drive(0, 1'b0, rnd64(), rnd64(), rnd64());
    reset_0 = 1'b1;
    for (int s = 0; s < 3; s++) last_o[s] = 64'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock_0);
      sample(0, ov, oo);
      n_cmp++;
      if (ov !== 1'b0 || oo !== 64'd0) begin
        n_err++; $display("FAIL midrst_idle@%0d: got v=%b o=%h want v=0 o=0", k, ov, oo);
      end
    end
    for (int i = 0; i < 3; i++) begin
      st_v[i] = 64'd1; st_a[i] = rnd64(); st_b[i] = rnd64(); st_r[i] = rnd64();
    end
    run_stream(0, 3, "post_reset");
  endtask

  task automatic test_random_o3();
    for (int i = 0; i < 1000; i++) begin
      st_v[i] = ($urandom_range(0, 4) != 0) ? 64'd1 : 64'd0;
      st_a[i] = rnd64();
      st_b[i] = rnd64();
      st_r[i] = rnd64();
    end
    run_stream(2, 1000, "random_o3");
  endtask

  initial begin
    test_reset();
    test_first_bundle();
    test_exhaustive();
    test_order1_w8();
    test_bubble();
    test_reset_mid();
    test_random_o3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
